// File: rtl/ft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ft_pkg
// Description : Types and constants shared by the fault-tolerance blocks.
//               Provides the lockstep checker state encoding, the
//               write-back record compared between cores, and the width
//               of the mismatch counter.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ft_pkg;

  localparam int FT_ADDR_W    = 5;
  localparam int FT_DATA_W    = 32;
  localparam int FT_ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    FT_MONITOR = 2'd0,
    FT_ERROR   = 2'd1,
    FT_RECOVER = 2'd2,
    FT_GUARD   = 2'd3
  } ft_chk_state_e;

  // One core's register-file write-back as seen in a single cycle.
  typedef struct packed {
    logic                 we;
    logic [FT_ADDR_W-1:0] waddr;
    logic [FT_DATA_W-1:0] wdata;
    logic [FT_DATA_W-1:0] pc;
  } ft_wb_t;

endpackage
`default_nettype wire

// File: rtl/ft_lockstep_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : ft_lockstep_checker_if
// Description : Bundle of the two cores' write-back/PC streams, the resume
//               handshake from the recovery controller and the checker's
//               commit/error/status outputs.
// Modports    : master - core/controller side (drives core streams, resume)
//               slave  - checker side (drives commit, error, busy, count)
// Revision    : 1.0 - initial release
// ============================================================================
interface ft_lockstep_checker_if
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH = FT_ADDR_W,
  parameter int DATA_WIDTH = FT_DATA_W
);

  logic                    a_we_i;
  logic                    b_we_i;
  logic [ADDR_WIDTH-1:0]   a_waddr_i;
  logic [ADDR_WIDTH-1:0]   b_waddr_i;
  logic [DATA_WIDTH-1:0]   a_wdata_i;
  logic [DATA_WIDTH-1:0]   b_wdata_i;
  logic [DATA_WIDTH-1:0]   a_pc_i;
  logic [DATA_WIDTH-1:0]   b_pc_i;
  logic                    resume_i;
  logic                    error_o;
  logic                    commit_we_o;
  logic [ADDR_WIDTH-1:0]   commit_addr_o;
  logic [DATA_WIDTH-1:0]   commit_data_o;
  logic [DATA_WIDTH-1:0]   commit_pc_o;
  logic                    busy_o;
  logic [FT_ERR_CNT_W-1:0] err_count_o;

  modport master (
    output a_we_i, b_we_i, a_waddr_i, b_waddr_i, a_wdata_i, b_wdata_i,
           a_pc_i, b_pc_i, resume_i,
    input  error_o, commit_we_o, commit_addr_o, commit_data_o, commit_pc_o,
           busy_o, err_count_o
  );

  modport slave (
    input  a_we_i, b_we_i, a_waddr_i, b_waddr_i, a_wdata_i, b_wdata_i,
           a_pc_i, b_pc_i, resume_i,
    output error_o, commit_we_o, commit_addr_o, commit_data_o, commit_pc_o,
           busy_o, err_count_o
  );

endinterface
`default_nettype wire

// File: rtl/ft_wb_compare.sv
`default_nettype none
// ============================================================================
// Module      : ft_wb_compare
// Description : Combinational comparison of two write-back records.
//               o_active is high when either core writes; o_mismatch is high
//               when active and any field (enable, address, data, PC)
//               differs. Kept separate so a TMR voter can reuse it.
// Ports       : i_a, i_b   - write-back records of the two cores
//               o_active   - at least one core is writing
//               o_mismatch - records disagree while active
// Revision    : 1.0 - initial release
// ============================================================================
module ft_wb_compare
  import ft_pkg::*;
(
  input  ft_wb_t i_a,
  input  ft_wb_t i_b,
  output logic   o_active,
  output logic   o_mismatch
);

  assign o_active   = i_a.we | i_b.we;
  // Whole-record inequality covers enable skew as well as field differences.
  assign o_mismatch = o_active & (i_a != i_b);

endmodule
`default_nettype wire

// File: rtl/ft_lockstep_checker.sv
`default_nettype none
// ============================================================================
// Module      : ft_lockstep_checker
// Description : Lockstep error detector. Registers both cores' write-back
//               streams, compares them, commits agreeing writes to the
//               shadow register file/PC and pulses error on divergence.
//               After an error, comparison stays masked through recovery
//               and for GUARD_CYCLES cycles after resume.
// Ports       : clk_i  - clock, rising edge
//               rst_ni - asynchronous reset, active low
//               bus    - ft_lockstep_checker_if.slave (core streams, resume,
//                        commit_*, error_o, busy_o, err_count_o)
// Config      : FT_ERR_COUNTER_EN - when defined, err_count_o is a
//               saturating count of detected mismatches; otherwise 0.
// Revision    : 1.0 - initial release
// ============================================================================
module ft_lockstep_checker
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH   = FT_ADDR_W,
  parameter int DATA_WIDTH   = FT_DATA_W,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  ft_lockstep_checker_if.slave  bus
);

  localparam logic [1:0] c_MONITOR = FT_MONITOR;
  localparam logic [1:0] c_ERROR   = FT_ERROR;
  localparam logic [1:0] c_RECOVER = FT_RECOVER;
  localparam logic [1:0] c_GUARD   = FT_GUARD;

  localparam int c_GUARD_W = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
  localparam logic [c_GUARD_W-1:0] c_GUARD_LOAD =
    c_GUARD_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

  ft_wb_t                 r_a;
  ft_wb_t                 r_b;
  logic                   w_active;
  logic                   w_mismatch;
  logic                   w_commit;
  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [c_GUARD_W-1:0]   r_guard_cnt;
  logic [c_GUARD_W-1:0]   w_guard_nxt;
  logic                   r_commit_we;
  logic [ADDR_WIDTH-1:0]  r_commit_addr;
  logic [DATA_WIDTH-1:0]  r_commit_data;
  logic [DATA_WIDTH-1:0]  r_commit_pc;

  // Stage 1: capture both cores every cycle, no enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      r_a.we    <= bus.a_we_i;
      r_a.waddr <= FT_ADDR_W'(bus.a_waddr_i);
      r_a.wdata <= FT_DATA_W'(bus.a_wdata_i);
      r_a.pc    <= FT_DATA_W'(bus.a_pc_i);
      r_b.we    <= bus.b_we_i;
      r_b.waddr <= FT_ADDR_W'(bus.b_waddr_i);
      r_b.wdata <= FT_DATA_W'(bus.b_wdata_i);
      r_b.pc    <= FT_DATA_W'(bus.b_pc_i);
    end
  end

  ft_wb_compare u_compare (
    .i_a        (r_a),
    .i_b        (r_b),
    .o_active   (w_active),
    .o_mismatch (w_mismatch)
  );

  // Mismatches only matter in MONITOR; other states ignore them entirely.
  always_comb begin
    w_state_nxt = r_state;
    w_guard_nxt = r_guard_cnt;
    case (r_state)
      c_MONITOR: begin
        if (w_mismatch) w_state_nxt = c_ERROR;
      end
      c_ERROR: begin
        w_state_nxt = c_RECOVER;
      end
      c_RECOVER: begin
        if (bus.resume_i) begin
          if (GUARD_CYCLES == 0) begin
            w_state_nxt = c_MONITOR;
          end else begin
            w_state_nxt = c_GUARD;
            w_guard_nxt = c_GUARD_LOAD;
          end
        end
      end
      c_GUARD: begin
        if (r_guard_cnt == '0) w_state_nxt = c_MONITOR;
        else                   w_guard_nxt = r_guard_cnt - 1'b1;
      end
      default: begin
        w_state_nxt = c_MONITOR;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= c_MONITOR;
      r_guard_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_guard_cnt <= w_guard_nxt;
    end
  end

  // x0 writes are compared but never forwarded to the shadow file.
  assign w_commit = (r_state == c_MONITOR) & w_active & ~w_mismatch &
                    (r_a.waddr != '0);

  // Commit payload holds its last value between strobes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_commit_we   <= 1'b0;
      r_commit_addr <= '0;
      r_commit_data <= '0;
      r_commit_pc   <= '0;
    end else begin
      r_commit_we <= w_commit;
      if (w_commit) begin
        r_commit_addr <= ADDR_WIDTH'(r_a.waddr);
        r_commit_data <= DATA_WIDTH'(r_a.wdata);
        r_commit_pc   <= DATA_WIDTH'(r_a.pc);
      end
    end
  end

  assign bus.commit_we_o   = r_commit_we;
  assign bus.commit_addr_o = r_commit_addr;
  assign bus.commit_data_o = r_commit_data;
  assign bus.commit_pc_o   = r_commit_pc;
  assign bus.error_o       = (r_state == c_ERROR);
  assign bus.busy_o        = (r_state != c_MONITOR);

`ifdef FT_ERR_COUNTER_EN
  logic [FT_ERR_CNT_W-1:0] r_err_cnt;

  // Counts MONITOR->ERROR transitions, sticking at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err_cnt <= '0;
    end else if ((r_state == c_MONITOR) && w_mismatch && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign bus.err_count_o = r_err_cnt;
`else
  assign bus.err_count_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ft_lockstep_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_ft_lockstep_checker
// Description : Self-checking bench for ft_lockstep_checker. Directed
//               write-back vectors push their expected commit/error event
//               (with the cycle it must appear in) into a queue; a monitor
//               on the falling edge pops and compares each DUT output event.
// Config      : FT_ERR_COUNTER_EN selects the expected err_count_o model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ft_lockstep_checker;
  import ft_pkg::*;

  localparam int GUARD    = 4;
  localparam int K_NONE   = 0;
  localparam int K_COMMIT = 1;
  localparam int K_ERR    = 2;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  ft_lockstep_checker_if #(.ADDR_WIDTH(FT_ADDR_W), .DATA_WIDTH(FT_DATA_W)) bus ();

  ft_lockstep_checker #(
    .ADDR_WIDTH   (FT_ADDR_W),
    .DATA_WIDTH   (FT_DATA_W),
    .GUARD_CYCLES (GUARD)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  typedef struct {
    int          cyc;
    bit          is_err;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   exp_errs = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Scoreboard monitor.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missed_event: no output at cycle %0d, required %s",
                 q[0].cyc, q[0].is_err ? "error_o" : "commit");
        void'(q.pop_front());
      end
      if (bus.error_o || bus.commit_we_o) begin
        n_cmp++;
        if (q.size() == 0 || q[0].cyc != cyc) begin
          n_bad++;
          $display("FAIL unexpected_event: cycle %0d got error_o=%0b commit_we_o=%0b addr=%0d data=%h pc=%h, required no output",
                   cyc, bus.error_o, bus.commit_we_o, bus.commit_addr_o,
                   bus.commit_data_o, bus.commit_pc_o);
        end else begin
          e = q.pop_front();
          if ((bus.error_o != e.is_err) || (bus.commit_we_o == e.is_err) ||
              (!e.is_err && ({bus.commit_addr_o, bus.commit_data_o, bus.commit_pc_o}
                             != {e.addr, e.data, e.pc}))) begin
            n_bad++;
            $display("FAIL event_cycle_%0d: got error_o=%0b commit_we_o=%0b addr=%0d data=%h pc=%h, required error_o=%0b addr=%0d data=%h pc=%h",
                     cyc, bus.error_o, bus.commit_we_o, bus.commit_addr_o,
                     bus.commit_data_o, bus.commit_pc_o, e.is_err, e.addr,
                     e.data, e.pc);
          end
        end
      end
    end
  end

  function automatic ft_wb_t wb(input bit we, input logic [4:0] ad,
                                input logic [31:0] d, input logic [31:0] p);
    ft_wb_t r;
    r.we = we; r.waddr = ad; r.wdata = d; r.pc = p;
    return r;
  endfunction

  function automatic int exp_cnt();
`ifdef FT_ERR_COUNTER_EN
    return exp_errs;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // Drive one cycle of both cores; result appears two edges later.
  task automatic wr(input ft_wb_t a, input ft_wb_t b, input int kind, input bit res);
    bus.a_we_i    = a.we;    bus.b_we_i    = b.we;
    bus.a_waddr_i = a.waddr; bus.b_waddr_i = b.waddr;
    bus.a_wdata_i = a.wdata; bus.b_wdata_i = b.wdata;
    bus.a_pc_i    = a.pc;    bus.b_pc_i    = b.pc;
    bus.resume_i  = res;
    if (kind == K_COMMIT) begin
      q.push_back('{cyc: cyc + 2, is_err: 1'b0, addr: a.waddr, data: a.wdata, pc: a.pc});
    end else if (kind == K_ERR) begin
      q.push_back('{cyc: cyc + 2, is_err: 1'b1, addr: 5'd0, data: 32'd0, pc: 32'd0});
      if (exp_errs < 255) exp_errs++;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) wr(wb(0, 0, 0, 0), wb(0, 0, 0, 0), K_NONE, 1'b0);
  endtask

  task automatic match(input logic [4:0] ad, input logic [31:0] d,
                       input logic [31:0] p, input int kind, input bit res);
    wr(wb(1, ad, d, p), wb(1, ad, d, p), kind, res);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_error"},  64'(bus.error_o),       64'd0);
    chk({tag, "_we"},     64'(bus.commit_we_o),   64'd0);
    chk({tag, "_addr"},   64'(bus.commit_addr_o), 64'd0);
    chk({tag, "_data"},   64'(bus.commit_data_o), 64'd0);
    chk({tag, "_pc"},     64'(bus.commit_pc_o),   64'd0);
    chk({tag, "_busy"},   64'(bus.busy_o),        64'd0);
    chk({tag, "_errcnt"}, 64'(bus.err_count_o),   64'd0);
  endtask

  initial begin
    bus.a_we_i = 0; bus.b_we_i = 0; bus.a_waddr_i = 0; bus.b_waddr_i = 0;
    bus.a_wdata_i = 0; bus.b_wdata_i = 0; bus.a_pc_i = 0; bus.b_pc_i = 0;
    bus.resume_i = 0;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk_zero_outputs("reset");
    rst_ni = 1'b1;

    // Identical streams commit with 2-cycle latency, back to back
    match(5'd5, 32'hDEADBEEF, 32'h100, K_COMMIT, 1'b0);
    match(5'd7, 32'h12345678, 32'h104, K_COMMIT, 1'b0);
    idle(3);
    chk("idle_busy", 64'(bus.busy_o), 64'd0);

    // Data mismatch; the following matched write is compared in ERROR
    wr(wb(1, 5, 32'hDEADBEEF, 32'h108), wb(1, 5, 32'hDEADBEEE, 32'h108), K_ERR, 1'b0);
    match(5'd6, 32'hCAFE0000, 32'h10C, K_NONE, 1'b0);
    chk("error_state_busy", 64'(bus.busy_o), 64'd1);
    idle(1);
    chk("errcnt_after_1", 64'(bus.err_count_o), 64'(exp_cnt()));
    // Mismatches during RECOVER are ignored
    wr(wb(1, 3, 32'h1, 32'h110), wb(1, 4, 32'h1, 32'h110), K_NONE, 1'b0);
    wr(wb(1, 3, 32'h1, 32'h114), wb(1, 3, 32'h1, 32'h118), K_NONE, 1'b0);
    idle(2);
    chk("recover_busy", 64'(bus.busy_o), 64'd1);

    // Resume: 4 masked cycles (last one carries a mismatch), 5th commits
    match(5'd1, 32'h11, 32'h200, K_NONE, 1'b1);
    match(5'd2, 32'h22, 32'h204, K_NONE, 1'b0);
    match(5'd3, 32'h33, 32'h208, K_NONE, 1'b0);
    wr(wb(1, 4, 32'h44, 32'h20C), wb(1, 4, 32'h44, 32'h20D), K_NONE, 1'b0);
    chk("last_guard_busy", 64'(bus.busy_o), 64'd1);
    match(5'd8, 32'h88, 32'h210, K_COMMIT, 1'b0);
    chk("after_guard_busy", 64'(bus.busy_o), 64'd0);
    chk("errcnt_after_guard", 64'(bus.err_count_o), 64'(exp_cnt()));

    // Enable skew: A writes, B does not
    wr(wb(1, 9, 32'h99, 32'h300), wb(0, 9, 32'h99, 32'h300), K_ERR, 1'b0);
    idle(2);
    wr(wb(1, 9, 32'h1, 32'h304), wb(1, 9, 32'h2, 32'h304), K_NONE, 1'b0);
    wr(wb(1, 9, 32'h3, 32'h308), wb(1, 9, 32'h4, 32'h308), K_NONE, 1'b0);
    // resume coincides with the compare of the mismatch above
    wr(wb(0, 0, 0, 0), wb(0, 0, 0, 0), K_NONE, 1'b1);
    idle(4);
    chk("errcnt_after_skew", 64'(bus.err_count_o), 64'(exp_cnt()));

    // x0 writes never commit; a later write proves MONITOR is live
    match(5'd0, 32'h5555, 32'h400, K_NONE, 1'b0);
    match(5'd10, 32'hA, 32'h404, K_COMMIT, 1'b0);
    idle(2);
    chk("held_commit_data", 64'(bus.commit_data_o), 64'hA);

    // Asynchronous reset in the middle of GUARD
    wr(wb(1, 12, 32'h1, 32'h500), wb(1, 12, 32'h1, 32'h501), K_ERR, 1'b0);
    idle(2);
    wr(wb(0, 0, 0, 0), wb(0, 0, 0, 0), K_NONE, 1'b1);
    idle(1);
    chk("guard_busy", 64'(bus.busy_o), 64'd1);
    #3;
    rst_ni   = 1'b0;
    exp_errs = 0;
    #1;
    chk_zero_outputs("midreset");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    match(5'd11, 32'hBB, 32'h504, K_COMMIT, 1'b0);
    idle(2);

    // Repeated error/resume rounds; count saturates at 255 when enabled
    for (int i = 0; i < 300; i++) begin
      wr(wb(1, 3, 32'h1, 32'h600), wb(1, 3, 32'h2, 32'h600), K_ERR, 1'b0);
      idle(2);
      wr(wb(0, 0, 0, 0), wb(0, 0, 0, 0), K_NONE, 1'b1);
      idle(4);
    end
    chk("errcnt_saturated", 64'(bus.err_count_o), 64'(exp_cnt()));
    match(5'd13, 32'hD00D, 32'h700, K_COMMIT, 1'b0);

    idle(4);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ft_lockstep_checker.md
# ft_lockstep_checker

Upstream error-detection stage of the fault-tolerance module. It compares the register-file write-back and PC streams of two lockstep cores, cycle by cycle. On agreement it forwards the write as a commit to the shadow register file and shadow PC. On divergence it raises a one-cycle `error_o` pulse into the recovery controller's `error_i`, then masks comparison until the controller signals resume and the pipelines have drained.

## Interface
- `ADDR_WIDTH`, 5: register address width; matches the recovery controller.
- `DATA_WIDTH`, 32: write-back data and PC width.
- `GUARD_CYCLES`, 4: cycles comparison stays masked after `resume_i`; 0 is legal.

- `clk_i` input 1: single clock; all state changes on the rising edge.
- `rst_ni` input 1: asynchronous reset, active-low.
- `a_we_i`, `b_we_i` input 1 each: core A / core B register write enable.
- `a_waddr_i`, `b_waddr_i` input ADDR_WIDTH each: write address.
- `a_wdata_i`, `b_wdata_i` input DATA_WIDTH each: write data.
- `a_pc_i`, `b_pc_i` input DATA_WIDTH each: PC of the writing instruction.
- `resume_i` input 1: from the controller's `resume_o`; ends recovery.
- `error_o` output 1: one-cycle mismatch pulse to the controller's `error_i`.
- `commit_we_o` output 1: shadow GPR write strobe.
- `commit_addr_o` output ADDR_WIDTH: shadow GPR address.
- `commit_data_o` output DATA_WIDTH: shadow GPR data.
- `commit_pc_o` output DATA_WIDTH: shadow PC value; valid with `commit_we_o`.
- `busy_o` output 1: high when not in MONITOR.
- `err_count_o` output 8: saturating mismatch count (see Configuration).

## Operation
- **Stage 1:** all eight core inputs are registered unconditionally every cycle.
- **Compare (combinational on stage 1):** `active = a_we | b_we`.
  - `mismatch = active & (a_we != b_we | waddr != | wdata != | pc !=)`.
  - With `active` low, nothing is compared and nothing is committed.
- **States:** MONITOR, ERROR, RECOVER, GUARD.
- **Transitions:**
  - MONITOR -> ERROR on `mismatch`.
  - ERROR -> RECOVER unconditionally, after exactly one cycle.
  - RECOVER -> GUARD on `resume_i`. If GUARD_CYCLES == 0, RECOVER -> MONITOR directly.
  - GUARD: the counter loads GUARD_CYCLES-1 on entry and decrements each cycle. GUARD -> MONITOR when the counter is 0.
- **Commit:** registered. Asserted only if the state is MONITOR, `active`, no `mismatch`, and `waddr != 0`. Writes to x0 are compared but never committed.
- **Outputs:**
  - `error_o` is a Moore output, high in ERROR only.
  - `busy_o` = state != MONITOR.
- **Masking:** mismatches in ERROR, RECOVER or GUARD are ignored and not counted.
- **resume_i outside RECOVER:** ignored.
- **Guard counter width:** `$clog2(GUARD_CYCLES+1)`, minimum 1.

## Timing
- **Reset values:** state MONITOR; all stage-1 registers, commit outputs, `error_o` and `err_count_o` are 0; `busy_o` is 0.
- **Latency:** inputs sampled at edge E0 are compared after E0.
  - `commit_*_o` or `error_o` is valid in the cycle following E1, i.e. 2 cycles after presentation.
- **Mismatching write:** never committed. The write following it is compared while in ERROR and is therefore also not committed.
- **Same-cycle mismatch and resume_i in RECOVER:** resume wins; the mismatch is ignored.
- **Mismatch on the last GUARD cycle:** ignored. The first compared write is the one evaluated in MONITOR.
- **Reset mid-recovery:** immediately returns to MONITOR with all outputs cleared; the pending guard count is discarded.

## Configuration
- Macro: `FT_ERR_COUNTER_EN`.
- **Defined:** an 8-bit counter increments on each MONITOR -> ERROR transition and saturates at 255. It is cleared only by reset.
- **Undefined:** no counter register exists; `err_count_o` is tied to 0. The port is present in both builds.

## Structure
- **Shared package `ft_pkg`:**
  - `ft_chk_state_e` enum (MONITOR, ERROR, RECOVER, GUARD).
  - Struct `ft_wb_t` {we, waddr, wdata, pc}, parameterised via package localparams, default widths 5/32.
  - Localparam `FT_ERR_CNT_W = 8`.
- **Sub-module `ft_wb_compare`:** purely combinational; takes two `ft_wb_t` and outputs `active` and `mismatch`. Reusable for a future TMR voter.
- **Top:** the stage-1 registers, FSM, guard counter, commit registers and the optional counter live in `ft_lockstep_checker`.

## Test plan
- **Identical streams:** both cores write x5 = 0xDEADBEEF, pc = 0x100.
  - Expect `commit_we_o` = 1, addr 5, data 0xDEADBEEF, pc 0x100, 2 cycles after input; `error_o` stays 0.
- **Data mismatch:** B writes 0xDEADBEEE.
  - Expect `error_o` high for exactly 1 cycle, no commit for that write or the next, `busy_o` = 1.
  - With the macro defined, `err_count_o` = 1.
- **Recovery sequence:** after the error, inject mismatches in RECOVER, then pulse `resume_i`, with GUARD_CYCLES = 4.
  - Expect no `error_o` and no commits for 4 cycles after resume.
  - The matched write on the 5th cycle commits.
- **Enable skew and x0:**
  - A writes, B does not: expect `error_o`.
  - Both write x0 identically: expect no commit and no error.
- **Async reset during GUARD:** `rst_ni` low mid-cycle.
  - Expect all outputs 0 immediately, state MONITOR.
  - The next matched write commits with 2-cycle latency.
- **Counter saturation (macro on):** 300 error/resume cycles.
  - Expect `err_count_o` = 255. With the macro off, it is constantly 0.
